power_sequencer: RTL and testbench

- Sequences the sub's power rails on and off in a fixed order, with a programmable dwell between rails.
- Monitors debounced fault inputs (kill switch, low battery, leak) and power-good feedback.
- Drives the shutdown vector consumed by the GPIO disable stage, and latches the fault cause until software clears it.
- Sits in top_level/power_management between the raw fault pins and the GPIO disable logic.

---
 rtl/power_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_power_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// Power rail sequencer: ordered rail ramp-up/ramp-down with a programmable dwell,
// debounced external fault monitoring, power-good supervision and a sticky fault record.
module power_sequencer #(
  parameter int NUM_RAILS       = 4,
  parameter int NUM_FAULTS      = 2,
  parameter int STEP_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear_fault,
  input  logic [NUM_FAULTS-1:0] fault_in,
  input  logic [NUM_RAILS-1:0]  rail_pgood,
  output logic [NUM_RAILS-1:0]  rail_en,
  output logic                  shutdown,
  output logic [NUM_FAULTS-1:0] fault_latched,
  output logic [NUM_RAILS-1:0]  pgood_fault,
  output logic [2:0]            state,
  output logic                  busy
);

  localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam int TMR_W = $clog2(STEP_CYCLES);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_ON        = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t                  state_r, state_nxt;
  logic [IDX_W-1:0]        idx_r, idx_nxt;
  logic [TMR_W-1:0]        timer_r, timer_nxt;
  logic [NUM_RAILS-1:0]    rail_en_nxt, pgood_fault_nxt;
  logic [NUM_FAULTS-1:0]   fault_latched_nxt;
  logic                    shutdown_nxt;

  logic [NUM_FAULTS-1:0]   fault_s1, fault_s2;
  logic [NUM_RAILS-1:0]    pgood_s1, pgood_s2;
  logic [DB_W-1:0]         db_cnt [NUM_FAULTS];
  logic [NUM_FAULTS-1:0]   fault_db;
  logic                    any_fault;
  logic                    timer_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_s1 <= '0;
      fault_s2 <= '0;
      pgood_s1 <= '0;
      pgood_s2 <= '0;
    end else begin
      fault_s1 <= fault_in;
      fault_s2 <= fault_s1;
      pgood_s1 <= rail_pgood;
      pgood_s2 <= pgood_s1;
    end
  end

  // Saturating run-length counters; a single low sample restarts the qualification.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FAULTS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (!fault_s2[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_MAX)
          db_cnt[i] <= db_cnt[i] + DB_ONE;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FAULTS; i++) fault_db[i] = (db_cnt[i] == DB_MAX);
  end

  assign any_fault  = |fault_db;
  assign timer_done = (timer_r == TMR_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_OFF;
      idx_r         <= '0;
      timer_r       <= '0;
      rail_en       <= '0;
      shutdown      <= 1'b1;
      fault_latched <= '0;
      pgood_fault   <= '0;
    end else begin
      state_r       <= state_nxt;
      idx_r         <= idx_nxt;
      timer_r       <= timer_nxt;
      rail_en       <= rail_en_nxt;
      shutdown      <= shutdown_nxt;
      fault_latched <= fault_latched_nxt;
      pgood_fault   <= pgood_fault_nxt;
    end
  end

  always_comb begin
    state_nxt         = state_r;
    idx_nxt           = idx_r;
    timer_nxt         = timer_r;
    rail_en_nxt       = rail_en;
    pgood_fault_nxt   = pgood_fault;
    fault_latched_nxt = fault_latched | fault_db;

    case (state_r)
      ST_OFF: begin
        if (any_fault) begin
          state_nxt = ST_FAULT;
        end else if (start) begin
          state_nxt      = ST_RAMP_UP;
          idx_nxt        = '0;
          timer_nxt      = '0;
          rail_en_nxt    = '0;
          rail_en_nxt[0] = 1'b1;
        end
      end

      ST_RAMP_UP: begin
        if (any_fault) begin
          state_nxt = ST_FAULT;
        end else if (stop) begin
          state_nxt = ST_RAMP_DOWN;
          timer_nxt = '0;
        end else if (timer_done) begin
          timer_nxt = '0;
          if (!pgood_s2[idx_r]) begin
            pgood_fault_nxt[idx_r] = 1'b1;
            state_nxt              = ST_FAULT;
          end else if (idx_r == LAST_IDX) begin
            state_nxt = ST_ON;
          end else begin
            idx_nxt              = idx_r + IDX_ONE;
            rail_en_nxt[idx_nxt] = 1'b1;
          end
        end else begin
          timer_nxt = timer_r + TMR_ONE;
        end
      end

      ST_ON: begin
        if (any_fault) begin
          state_nxt = ST_FAULT;
        end else if (~pgood_s2 != '0) begin
          pgood_fault_nxt = pgood_fault | ~pgood_s2;
          state_nxt       = ST_FAULT;
        end else if (stop) begin
          state_nxt = ST_RAMP_DOWN;
          idx_nxt   = LAST_IDX;
          timer_nxt = '0;
        end
      end

      ST_RAMP_DOWN: begin
        if (any_fault) begin
          state_nxt = ST_FAULT;
        end else if (timer_done) begin
          timer_nxt          = '0;
          rail_en_nxt[idx_r] = 1'b0;
          if (idx_r == '0)
            state_nxt = ST_OFF;
          else
            idx_nxt = idx_r - IDX_ONE;
        end else begin
          timer_nxt = timer_r + TMR_ONE;
        end
      end

      ST_FAULT: begin
        if (clear_fault && !any_fault) begin
          state_nxt         = ST_OFF;
          fault_latched_nxt = '0;
          pgood_fault_nxt   = '0;
        end
      end

      default: state_nxt = ST_FAULT;
    endcase

    // Fault entry drops every rail at once rather than sequencing them down.
    if (state_nxt == ST_FAULT) rail_en_nxt = '0;
    shutdown_nxt = (state_nxt != ST_ON);
  end

  assign state = state_r;
  assign busy  = (state_r == ST_RAMP_UP) || (state_r == ST_RAMP_DOWN);

endmodule

// File: tb/tb_power_sequencer.sv
// Directed testbench for power_sequencer with a short dwell and debounce window.
module tb_power_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, clear_fault;
  logic [1:0] fault_in;
  logic [3:0] rail_pgood;
  logic [3:0] rail_en;
  logic       shutdown;
  logic [1:0] fault_latched;
  logic [3:0] pgood_fault;
  logic [2:0] state;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  power_sequencer #(
    .NUM_RAILS(4), .NUM_FAULTS(2), .STEP_CYCLES(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear_fault(clear_fault),
    .fault_in(fault_in), .rail_pgood(rail_pgood), .rail_en(rail_en), .shutdown(shutdown),
    .fault_latched(fault_latched), .pgood_fault(pgood_fault), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; stop = 0; clear_fault = 0; fault_in = '0; rail_pgood = 4'b1111;
    tick(3);
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    tests_run++; if (rail_en !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_rail_en: got %b expected 0000", rail_en); end
    tests_run++; if (shutdown !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: got shutdown=%b busy=%b expected 1/0", shutdown, busy); end
    tests_run++; if (fault_latched !== 2'b00 || pgood_fault !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_sticky: got %b/%b expected 00/0000", fault_latched, pgood_fault); end
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_ramp_up();
    logic [3:0] exp_en [4];
    exp_en = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    start = 1'b1; tick(1); start = 1'b0;
    tests_run++; if (rail_en !== exp_en[0] || state !== 3'd1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_up_first: got en=%b st=%0d busy=%b expected 0001/1/1", rail_en, state, busy); end
    for (int k = 1; k < 4; k++) begin
      tick(4);
      tests_run++; if (rail_en !== exp_en[k] || shutdown !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_up_step%0d: got en=%b sd=%b expected %b/1", k, rail_en, shutdown, exp_en[k]); end
    end
    tick(4);
    tests_run++; if (state !== 3'd2 || shutdown !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_up_on: got st=%0d sd=%b busy=%b expected 2/0/0", state, shutdown, busy); end
  endtask

  task automatic test_ramp_down();
    logic [3:0] exp_en [4];
    exp_en = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    stop = 1'b1; tick(1); stop = 1'b0;
    tests_run++; if (state !== 3'd3 || rail_en !== 4'b1111 || shutdown !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_down_entry: got st=%0d en=%b sd=%b expected 3/1111/1", state, rail_en, shutdown); end
    for (int k = 0; k < 4; k++) begin
      tick(4);
      tests_run++; if (rail_en !== exp_en[k]) begin tests_failed++; $display("[TB] FAIL ramp_down_step%0d: got %b expected %b", k, rail_en, exp_en[k]); end
    end
    tests_run++; if (state !== 3'd0 || shutdown !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_down_off: got st=%0d sd=%b expected 0/1", state, shutdown); end
  endtask

  task automatic test_debounce();
    fault_in = 2'b10; tick(7); fault_in = 2'b00;
    tick(6);
    tests_run++; if (state !== 3'd0 || fault_latched !== 2'b00) begin tests_failed++; $display("[TB] FAIL debounce_short: got st=%0d lat=%b expected 0/00", state, fault_latched); end
    fault_in = 2'b10;
    tick(9);
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("[TB] FAIL debounce_early: got st=%0d expected 0", state); end
    tick(3);
    tests_run++; if (state !== 3'd4 || fault_latched !== 2'b10 || rail_en !== 4'b0000 || shutdown !== 1'b1) begin tests_failed++; $display("[TB] FAIL debounce_fault: got st=%0d lat=%b en=%b sd=%b expected 4/10/0000/1", state, fault_latched, rail_en, shutdown); end
  endtask

  task automatic test_clear_fault();
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    tick(1);
    tests_run++; if (state !== 3'd4 || fault_latched !== 2'b10) begin tests_failed++; $display("[TB] FAIL clear_ignored: got st=%0d lat=%b expected 4/10", state, fault_latched); end
    fault_in = 2'b00; tick(5);
    tests_run++; if (fault_latched !== 2'b10) begin tests_failed++; $display("[TB] FAIL latch_sticky: got %b expected 10", fault_latched); end
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    tests_run++; if (state !== 3'd0 || fault_latched !== 2'b00 || pgood_fault !== 4'b0000) begin tests_failed++; $display("[TB] FAIL clear_accepted: got st=%0d lat=%b pg=%b expected 0/00/0000", state, fault_latched, pgood_fault); end
  endtask

  task automatic test_pgood_fault();
    rail_pgood = 4'b1011; tick(3);
    start = 1'b1; tick(1); start = 1'b0;
    tick(11);
    tests_run++; if (state !== 3'd1 || rail_en !== 4'b0111) begin tests_failed++; $display("[TB] FAIL pgood_before: got st=%0d en=%b expected 1/0111", state, rail_en); end
    tick(1);
    tests_run++; if (state !== 3'd4 || pgood_fault !== 4'b0100 || rail_en !== 4'b0000) begin tests_failed++; $display("[TB] FAIL pgood_fault: got st=%0d pg=%b en=%b expected 4/0100/0000", state, pgood_fault, rail_en); end
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    tests_run++; if (state !== 3'd0 || pgood_fault !== 4'b0000) begin tests_failed++; $display("[TB] FAIL pgood_clear: got st=%0d pg=%b expected 0/0000", state, pgood_fault); end
    rail_pgood = 4'b1111; tick(3);
  endtask

  task automatic test_stop_during_ramp();
    start = 1'b1; tick(1); start = 1'b0;
    tick(4);
    stop = 1'b1; tick(1); stop = 1'b0;
    tests_run++; if (state !== 3'd3 || rail_en !== 4'b0011) begin tests_failed++; $display("[TB] FAIL stop_ramp_entry: got st=%0d en=%b expected 3/0011", state, rail_en); end
    tick(4);
    tests_run++; if (rail_en !== 4'b0001) begin tests_failed++; $display("[TB] FAIL stop_ramp_rail1: got %b expected 0001", rail_en); end
    tick(4);
    tests_run++; if (rail_en !== 4'b0000 || state !== 3'd0) begin tests_failed++; $display("[TB] FAIL stop_ramp_off: got en=%b st=%0d expected 0000/0", rail_en, state); end
  endtask

  task automatic test_start_with_fault();
    fault_in = 2'b01; tick(10);
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("[TB] FAIL start_fault_pre: got st=%0d expected 0", state); end
    start = 1'b1; tick(1); start = 1'b0;
    tests_run++; if (state !== 3'd4 || rail_en !== 4'b0000 || fault_latched !== 2'b01) begin tests_failed++; $display("[TB] FAIL start_fault: got st=%0d en=%b lat=%b expected 4/0000/01", state, rail_en, fault_latched); end
    fault_in = 2'b00; tick(5);
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid_ramp();
    start = 1'b1; tick(1); start = 1'b0;
    tick(5);
    reset = 1'b1; #1;
    tests_run++; if (rail_en !== 4'b0000 || state !== 3'd0 || shutdown !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_mid_ramp: got en=%b st=%0d sd=%b expected 0000/0/1", rail_en, state, shutdown); end
    tick(2); reset = 1'b0; tick(2);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_debounce();
    test_clear_fault();
    test_pgood_fault();
    test_stop_during_ramp();
    test_start_with_fault();
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
